// File: rtl/cycle_decoder.sv
// cycle_decoder
// Monitors the four seven-segment digit buses of the rotating-segment
// animator. It recovers the committed animation position, the direction of
// the last step and a net lap count, and it raises sticky flags for skipped
// or malformed frames.
//
// Ports
//   clk, rst          system clock, asynchronous active-high reset
//   sseg0..sseg3      digit buses (active-low segments, bit 7 = dp)
//   err_clr           synchronous clear of err_skip / err_bad
//   pos               committed position 0..7
//   valid             a legal position is committed (TRACK state)
//   step              one-cycle pulse on an adjacent position change
//   dir               direction of last step (1 = +1, 0 = -1)
//   laps              net lap count, wraps modulo 2^LAP_W
//   err_skip          sticky: non-adjacent jump between legal positions
//   err_bad           sticky: illegal frame committed
module cycle_decoder #(
    parameter int STABLE = 4,
    parameter int LAP_W  = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [7:0]       sseg0,
    input  logic [7:0]       sseg1,
    input  logic [7:0]       sseg2,
    input  logic [7:0]       sseg3,
    input  logic             err_clr,
    output logic [2:0]       pos,
    output logic             valid,
    output logic             step,
    output logic             dir,
    output logic [LAP_W-1:0] laps,
    output logic             err_skip,
    output logic             err_bad
);

    localparam logic [7:0] TOP  = 8'b10011100;
    localparam logic [7:0] BOT  = 8'b10100011;
    localparam logic [7:0] NONE = 8'hFF;
    localparam logic [7:0] STB  = 8'(STABLE);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_TRACK = 1'b1;

    logic [31:0] frame;
    logic [31:0] cand;
    logic [31:0] last_frame;
    logic [7:0]  cnt;
    logic [7:0]  cnt_nxt;
    logic [0:0]  state;
    logic        commit;
    logic        legal;
    logic        blank;
    logic [2:0]  lpos;
    logic        fwd;
    logic        bwd;
    logic        skip_ev;
    logic        bad_ev;

    assign frame = {sseg3, sseg2, sseg1, sseg0};
    assign valid = (state == ST_TRACK);

    // Frame classification of the current input word
    always_comb begin
        legal = 1'b0;
        lpos  = 3'd0;
        blank = (frame == {4{NONE}});
        case (frame)
            {NONE, NONE, NONE, TOP}: begin legal = 1'b1; lpos = 3'd0; end
            {NONE, NONE, TOP, NONE}: begin legal = 1'b1; lpos = 3'd1; end
            {NONE, TOP, NONE, NONE}: begin legal = 1'b1; lpos = 3'd2; end
            {TOP, NONE, NONE, NONE}: begin legal = 1'b1; lpos = 3'd3; end
            {BOT, NONE, NONE, NONE}: begin legal = 1'b1; lpos = 3'd4; end
            {NONE, BOT, NONE, NONE}: begin legal = 1'b1; lpos = 3'd5; end
            {NONE, NONE, BOT, NONE}: begin legal = 1'b1; lpos = 3'd6; end
            {NONE, NONE, NONE, BOT}: begin legal = 1'b1; lpos = 3'd7; end
            default: ;
        endcase
    end

    // Stability filter: a commit happens only on the edge where the hold
    // count first reaches STABLE, and only for a frame different from the
    // last committed one, so a held frame commits at most once.
    always_comb begin
        commit = 1'b0;
        if (frame != cand) begin
            cnt_nxt = 8'd1;
            commit  = (STB == 8'd1);
        end else if (cnt < STB) begin
            cnt_nxt = cnt + 8'd1;
            commit  = (cnt_nxt == STB);
        end else begin
            cnt_nxt = cnt;
        end
        if (frame == last_frame)
            commit = 1'b0;
    end

    assign fwd     = (lpos == pos + 3'd1);
    assign bwd     = (lpos == pos - 3'd1);
    assign skip_ev = commit && legal && (state == ST_TRACK) && !fwd && !bwd;
    assign bad_ev  = commit && !legal && !blank;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cand       <= {4{NONE}};
            cnt        <= STB;
            last_frame <= {4{NONE}};
            state      <= ST_IDLE;
            pos        <= 3'd0;
            step       <= 1'b0;
            dir        <= 1'b0;
            laps       <= '0;
            err_skip   <= 1'b0;
            err_bad    <= 1'b0;
        end else begin
            cand <= frame;
            cnt  <= cnt_nxt;
            step <= 1'b0;
            if (commit) begin
                last_frame <= frame;
                if (blank) begin
                    state <= ST_IDLE;
                end else if (legal) begin
                    pos <= lpos;
                    if (state == ST_IDLE) begin
                        state <= ST_TRACK;
                    end else if (fwd) begin
                        step <= 1'b1;
                        dir  <= 1'b1;
                        if (pos == 3'd7)
                            laps <= laps + LAP_W'(1);
                    end else if (bwd) begin
                        step <= 1'b1;
                        dir  <= 1'b0;
                        if (pos == 3'd0)
                            laps <= laps - LAP_W'(1);
                    end
                end
            end
            // A new error on the same edge as err_clr takes precedence
            err_skip <= (err_skip && !err_clr) || skip_ev;
            err_bad  <= (err_bad && !err_clr) || bad_ev;
        end
    end

endmodule

// File: tb/tb_cycle_decoder.sv
module tb_cycle_decoder;

    localparam logic [7:0] TOP  = 8'b10011100;
    localparam logic [7:0] BOT  = 8'b10100011;
    localparam logic [7:0] NONE = 8'hFF;
    localparam logic [31:0] BLANKF = {NONE, NONE, NONE, NONE};
    localparam logic [31:0] BADF   = {NONE, BOT, NONE, TOP};

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic [7:0] sseg0 = NONE, sseg1 = NONE, sseg2 = NONE, sseg3 = NONE;
    logic       err_clr = 1'b0;
    logic [2:0] pos;
    logic       valid, step, dir, err_skip, err_bad;
    logic [7:0] laps;

    int ncmp = 0;
    int nfail = 0;
    int steps;

    cycle_decoder #(.STABLE(4), .LAP_W(8)) dut (
        .clk(clk), .rst(rst),
        .sseg0(sseg0), .sseg1(sseg1), .sseg2(sseg2), .sseg3(sseg3),
        .err_clr(err_clr),
        .pos(pos), .valid(valid), .step(step), .dir(dir), .laps(laps),
        .err_skip(err_skip), .err_bad(err_bad)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] frame;
        logic        clr;
        int          hold;
        logic [2:0]  epos;
        logic        evalid;
        logic        edir;
        logic [7:0]  elaps;
        logic        eskip;
        logic        ebad;
        int          esteps;
    } vec_t;

    vec_t tbl[$];

    function automatic logic [31:0] fr(input int p);
        case (p)
            0: return {NONE, NONE, NONE, TOP};
            1: return {NONE, NONE, TOP, NONE};
            2: return {NONE, TOP, NONE, NONE};
            3: return {TOP, NONE, NONE, NONE};
            4: return {BOT, NONE, NONE, NONE};
            5: return {NONE, BOT, NONE, NONE};
            6: return {NONE, NONE, BOT, NONE};
            default: return {NONE, NONE, NONE, BOT};
        endcase
    endfunction

    function automatic vec_t mk(input logic [31:0] f, input logic c, input int h,
                                input int p, input logic v, input logic d,
                                input logic [7:0] l, input logic es, input logic eb,
                                input int ns);
        vec_t r;
        r.frame = f; r.clr = c; r.hold = h; r.epos = 3'(p); r.evalid = v;
        r.edir = d; r.elaps = l; r.eskip = es; r.ebad = eb; r.esteps = ns;
        return r;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        ncmp++;
        if (act !== exp) begin
            nfail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic drive(input logic [31:0] f);
        {sseg3, sseg2, sseg1, sseg0} = f;
    endtask

    // Advance n edges, sampling 1 time unit after each edge and counting pulses
    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
            #1;
            if (step === 1'b1) steps++;
        end
    endtask

    task automatic chk_all(input string tag, input int p, input logic v, input logic d,
                           input logic [7:0] l, input logic es, input logic eb);
        chk({tag, ".pos"}, 32'(pos), 32'(p));
        chk({tag, ".valid"}, 32'(valid), 32'(v));
        chk({tag, ".dir"}, 32'(dir), 32'(d));
        chk({tag, ".laps"}, 32'(laps), 32'(l));
        chk({tag, ".err_skip"}, 32'(err_skip), 32'(es));
        chk({tag, ".err_bad"}, 32'(err_bad), 32'(eb));
    endtask

    initial begin
        // Reset state
        #12;
        chk_all("reset", 0, 0, 0, 8'h00, 0, 0);
        chk("reset.step", 32'(step), 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        // Latency: commit on the 4th edge after the frame appears
        drive(fr(0));
        steps = 0;
        for (int e = 1; e <= 4; e++) begin
            run(1);
            chk($sformatf("lat.edge%0d.valid", e), 32'(valid), (e == 4) ? 32'd1 : 32'd0);
        end
        chk_all("lat", 0, 1, 0, 8'h00, 0, 0);
        chk("lat.steps", 32'(steps), 32'd0);

        // Forward sweep 1..7, 0 (lap +1)
        for (int p = 1; p <= 7; p++) tbl.push_back(mk(fr(p), 0, 10, p, 1, 1, 8'h00, 0, 0, 1));
        tbl.push_back(mk(fr(0), 0, 10, 0, 1, 1, 8'h01, 0, 0, 1));
        // Backward across the seam (lap -1), then down to 0
        tbl.push_back(mk(fr(7), 0, 10, 7, 1, 0, 8'h00, 0, 0, 1));
        for (int p = 6; p >= 0; p--) tbl.push_back(mk(fr(p), 0, 10, p, 1, 0, 8'h00, 0, 0, 1));
        tbl.push_back(mk(fr(7), 0, 10, 7, 1, 0, 8'hFF, 0, 0, 1));
        for (int p = 6; p >= 1; p--) tbl.push_back(mk(fr(p), 0, 10, p, 1, 0, 8'hFF, 0, 0, 1));
        // Skip 1 -> 4, then clear
        tbl.push_back(mk(fr(4), 0, 10, 4, 1, 0, 8'hFF, 1, 0, 0));
        tbl.push_back(mk(fr(4), 1, 2, 4, 1, 0, 8'hFF, 0, 0, 0));
        // Bad frame, blank, resync at pos 2, clear
        tbl.push_back(mk(BADF, 0, 10, 4, 1, 0, 8'hFF, 0, 1, 0));
        tbl.push_back(mk(BLANKF, 0, 10, 4, 0, 0, 8'hFF, 0, 1, 0));
        tbl.push_back(mk(fr(2), 0, 10, 2, 1, 0, 8'hFF, 0, 1, 0));
        tbl.push_back(mk(fr(2), 1, 2, 2, 1, 0, 8'hFF, 0, 0, 0));

        foreach (tbl[i]) begin
            drive(tbl[i].frame);
            err_clr = tbl[i].clr;
            steps = 0;
            run(tbl[i].hold);
            err_clr = 1'b0;
            chk_all($sformatf("vec%0d", i), tbl[i].epos, tbl[i].evalid, tbl[i].edir,
                    tbl[i].elaps, tbl[i].eskip, tbl[i].ebad);
            chk($sformatf("vec%0d.steps", i), 32'(steps), 32'(tbl[i].esteps));
        end

        // Bad frame, then a 3-cycle glitch to an adjacent position: no commit
        drive(BADF); steps = 0; run(10);
        chk("glitch.bad", 32'(err_bad), 32'd1);
        drive(fr(3)); run(3);
        drive(BADF); run(10);
        chk("glitch.steps", 32'(steps), 32'd0);
        chk("glitch.pos", 32'(pos), 32'd2);
        chk("glitch.skip", 32'(err_skip), 32'd0);

        // err_clr held across a skip commit: the set wins, err_bad clears
        drive(fr(5)); err_clr = 1'b1; steps = 0; run(4);
        err_clr = 1'b0;
        chk_all("setwins", 5, 1, 0, 8'hFF, 1, 0);
        chk("setwins.steps", 32'(steps), 32'd0);

        // Reset mid-count; the held frame then resyncs without a step
        drive(fr(6)); run(2);
        rst = 1'b1; #1;
        chk_all("midrst", 0, 0, 0, 8'h00, 0, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        steps = 0;
        run(3);
        chk("midrst.early", 32'(valid), 32'd0);
        run(1);
        chk_all("midrst.resync", 6, 1, 0, 8'h00, 0, 0);
        chk("midrst.steps", 32'(steps), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule

// File: doc/cycle_decoder.md
# cycle_decoder

Receiving end of the rotating-segment display interface. Watches the four 8-bit seven-segment digit buses driven by the clockwise/counter-clockwise segment animator. Recovers the animation position, step direction and lap count, and flags malformed or skipped frames. Sits beside the display driver as an on-chip monitor; its outputs feed debug LEDs and the verification scoreboard.

## Interface
- `STABLE`, default 4: consecutive sampling edges a pattern must be present before it is committed (range 1..255).
- `LAP_W`, default 8: width of the signed lap counter (two's complement, wraps).
- `clk`  in  1  system clock
- `rst`  in  1  asynchronous, active-high reset
- `sseg0`..`sseg3`  in  8 each  digit buses, active-low segments, bit 7 = dp; same clock domain
- `err_clr`  in  1  synchronous clear of both sticky error flags
- `pos`  out  3  committed position 0..7
- `valid`  out  1  a legal position is currently committed
- `step`  out  1  one-cycle pulse on an adjacent position change
- `dir`  out  1  direction of last step: 1 = forward (+1), 0 = backward (−1)
- `laps`  out  LAP_W  net lap count
- `err_skip`  out  1  sticky: non-adjacent jump between legal positions
- `err_bad`  out  1  sticky: illegal frame committed

## Operation
- Digit codes: TOP = 8'b10011100, BOT = 8'b10100011, NONE = 8'hFF.
- Position map:
  - sseg0=TOP → 0, sseg1=TOP → 1, sseg2=TOP → 2, sseg3=TOP → 3.
  - sseg3=BOT → 4, sseg2=BOT → 5, sseg1=BOT → 6, sseg0=BOT → 7.
- Frame classes:
  - LEGAL: exactly one digit is TOP or BOT and the other three are NONE.
  - BLANK: all four digits are NONE.
  - BAD: anything else.
- Filter: holds the 32-bit candidate frame and a hold counter that saturates at STABLE.
  - On any edge where the inputs differ from the candidate, the candidate is reloaded and the count restarts at 1.
  - A frame is committed on the edge where the count reaches STABLE, and only when it differs from the last committed frame.
  - Only one commit occurs per distinct frame.
- FSM has two states, IDLE (valid=0) and TRACK (valid=1).
  - IDLE + LEGAL commit → TRACK; `pos` loads; no step, no lap change. This is a resync.
  - TRACK + LEGAL commit with pos' = pos+1 mod 8: `step`=1, `dir`=1. If pos was 7 and pos' is 0, `laps`+1.
  - TRACK + LEGAL commit with pos' = pos−1 mod 8: `step`=1, `dir`=0. If pos was 0 and pos' is 7, `laps`−1.
  - TRACK + LEGAL commit with any other pos': `err_skip` set, `pos` loads, no step, `dir` held.
  - Any state + BLANK commit → IDLE; `pos`, `dir` and `laps` hold.
  - Any state + BAD commit: `err_bad` set; state, `pos` and `laps` unchanged.
- Errors are sticky until `err_clr`. If `err_clr` and a new error event fall on the same edge, the set wins.
- `laps` wraps modulo 2^LAP_W in both directions.

## Timing
- Reset (async, immediate):
  - pos=0, valid=0, step=0, dir=0, laps=0, err_skip=0, err_bad=0.
  - Candidate = all-NONE with count = STABLE, so an all-NONE input after reset causes no commit.
- Latency: a frame first present before edge k and held commits at edge k+STABLE−1. All outputs are registered and change right after that edge. With STABLE=1 the latency is one edge.
- A frame that changes before reaching STABLE is discarded silently; no error.
- `step` is high for exactly one cycle per accepted step. Back-to-back steps are possible only with STABLE=1.
- Reset asserted mid-count or mid-pulse aborts everything; the first frame after release is treated as a resync.

## Test plan
- Reset, then hold sseg0=TOP and the others NONE for 4 cycles → valid=1, pos=0 at the 4th edge, step=0, laps=0.
- Forward sweep 0→7→0, each frame held 10 cycles → 8 step pulses, dir=1, laps=1, no errors.
- From pos=0, apply sseg0=BOT (pos 7) → step=1, dir=0, laps=−1 (8'hFF); continue 7→6 → laps unchanged.
- From pos=1, apply sseg3=BOT (pos 4) → err_skip=1, pos=4, no step. Then `err_clr` → err_skip=0.
- Apply sseg0=TOP and sseg2=BOT together, then a 3-cycle glitch to sseg1=TOP with STABLE=4 → err_bad=1 from the first frame; the glitch gets no commit and pos is unchanged.
- From TRACK, apply BLANK → valid=0, pos held. Then sseg2=TOP → valid=1, pos=2, no step or error regardless of the prior pos.
